// File: rtl/inverse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inverse_pkg
//  Description : Shared types and default constants for the matrix-inverse
//                feeder. Provides the element type, the run FSM state enum,
//                default DIM/WIDTH/RUN_CYCLES values, the core step-count
//                width and a helper returning the final step count.
//  Revision    : 1.0 - initial release
// ============================================================================
package inverse_pkg;

  localparam int DIM        = 4;    // matrix dimension (DIM x DIM elements)
  localparam int WIDTH      = 27;   // fixed-point element width
  localparam int RUN_CYCLES = 229;  // enabled cycles per inverse run, 2..256
  localparam int COUNT_W    = 8;    // width of core_count

  typedef logic [WIDTH-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } run_state_e;

  // Final step count of a run, as a COUNT_W-bit value.
  function automatic logic [COUNT_W-1:0] last_count(input int run_cycles);
    return COUNT_W'(run_cycles - 1);
  endfunction

endpackage : inverse_pkg
`default_nettype wire

// File: rtl/inverse_feeder_bank.sv
`default_nettype none
// ============================================================================
//  Module      : inverse_feeder_bank
//  Description : One matrix buffer. Single write port, single registered read
//                port (one-cycle read latency). Contents are never reset.
//  Ports       : clk        - clock
//                wr_en_i    - write strobe
//                wr_addr_i  - write element index
//                wr_data_i  - write element value
//                rd_addr_i  - read element index
//                rd_data_o  - element at rd_addr_i, registered
//  Revision    : 1.0 - initial release
// ============================================================================
module inverse_feeder_bank
  import inverse_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 27
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule : inverse_feeder_bank
`default_nettype wire

// File: rtl/inverse_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : inverse_feeder
//  Description : Upstream stage of the matrix-inverse engine. Buffers a
//                DIM x DIM matrix streamed over valid/ready, then drives the
//                inverse core through one run: a one-cycle core reset, then
//                RUN_CYCLES enabled cycles with a step count, with done on
//                the final cycle. The core reads the buffered matrix through
//                a registered random-access port.
//  Config      : INVERSE_FEEDER_PINGPONG_EN - when defined, two banks so a
//                new matrix can stream in while the previous one runs; when
//                undefined, a single bank and input is blocked while busy.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                in_valid/in_ready  - element handshake
//                in_data            - element, row-major
//                core_rst           - core reset (rst and START cycle)
//                core_en            - core enable (RUN cycles)
//                core_count         - step count within the run
//                core_addr          - element index requested by the core
//                core_data          - element read, one-cycle latency
//                busy               - run FSM not idle
//                done               - pulse on the final run cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module inverse_feeder
  import inverse_pkg::COUNT_W;
  import inverse_pkg::run_state_e;
  import inverse_pkg::IDLE;
  import inverse_pkg::START;
  import inverse_pkg::RUN;
  import inverse_pkg::last_count;
#(
  parameter int DIM        = inverse_pkg::DIM,
  parameter int WIDTH      = inverse_pkg::WIDTH,
  parameter int RUN_CYCLES = inverse_pkg::RUN_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       core_rst,
  output logic                       core_en,
  output logic [COUNT_W-1:0]         core_count,
  input  logic [$clog2(DIM*DIM)-1:0] core_addr,
  output logic [WIDTH-1:0]           core_data,
  output logic                       busy,
  output logic                       done
);

  localparam int                 DEPTH  = DIM * DIM;
  localparam int                 ADDR_W = $clog2(DEPTH);
  localparam logic [COUNT_W-1:0] C_LAST = last_count(RUN_CYCLES);
`ifdef INVERSE_FEEDER_PINGPONG_EN
  localparam int                 NBANKS = 2;
`else
  localparam int                 NBANKS = 1;
`endif

  // --------------------------------------------------------------------------
  // Fill side
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [NBANKS-1:0] full_q, full_d;
  logic              fill_full;
  logic              run_full;
  logic              accept;
  logic              wr_last;
  logic              run_release;

  run_state_e         state_q;
  logic               core_rst_q;
  logic               core_en_q;
  logic               busy_q;
  logic               done_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_inc;

  logic [WIDTH-1:0]  rd_data0;

`ifdef INVERSE_FEEDER_PINGPONG_EN
  logic              fill_bank_q;
  logic              run_bank_q;
  logic              rd_sel_q;      // bank that produced the current core_data
  logic [WIDTH-1:0]  rd_data1;

  assign fill_full = full_q[fill_bank_q];
  assign run_full  = full_q[run_bank_q];
  assign in_ready  = !rst && !fill_full;
`else
  assign fill_full = full_q[0];
  assign run_full  = full_q[0];
  // Single bank: the core is reading the only buffer while busy.
  assign in_ready  = !rst && !fill_full && !busy_q;
`endif

  assign accept      = in_valid && in_ready;
  assign wr_last     = (wr_ptr_q == ADDR_W'(DEPTH - 1));
  assign run_release = (state_q == RUN) && (count_q == C_LAST);
  assign count_inc   = count_q + 1'b1;

  // A fill completion and a run release never target the same bank: the
  // fill bank is only writable while it is empty, and the run bank is only
  // released while it is full.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    full_d   = full_q;
`ifdef INVERSE_FEEDER_PINGPONG_EN
    if (run_release)       full_d[run_bank_q]  = 1'b0;
    if (accept && wr_last) full_d[fill_bank_q] = 1'b1;
`else
    if (run_release)       full_d[0] = 1'b0;
    if (accept && wr_last) full_d[0] = 1'b1;
`endif
    if (accept) begin
      wr_ptr_d = wr_last ? '0 : wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      full_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
    end
  end

`ifdef INVERSE_FEEDER_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_bank_q <= 1'b0;
      run_bank_q  <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      fill_bank_q <= fill_bank_q ^ (accept && wr_last);
      run_bank_q  <= run_bank_q ^ run_release;
      rd_sel_q    <= run_bank_q;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
`ifdef INVERSE_FEEDER_PINGPONG_EN
  inverse_feeder_bank #(
    .DEPTH  (DEPTH),
    .DATA_W (WIDTH)
  ) u_bank0 (
    .clk       (clk),
    .wr_en_i   (accept && (fill_bank_q == 1'b0)),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data),
    .rd_addr_i (core_addr),
    .rd_data_o (rd_data0)
  );

  inverse_feeder_bank #(
    .DEPTH  (DEPTH),
    .DATA_W (WIDTH)
  ) u_bank1 (
    .clk       (clk),
    .wr_en_i   (accept && (fill_bank_q == 1'b1)),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data),
    .rd_addr_i (core_addr),
    .rd_data_o (rd_data1)
  );

  assign core_data = rd_sel_q ? rd_data1 : rd_data0;
`else
  inverse_feeder_bank #(
    .DEPTH  (DEPTH),
    .DATA_W (WIDTH)
  ) u_bank0 (
    .clk       (clk),
    .wr_en_i   (accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data),
    .rd_addr_i (core_addr),
    .rd_data_o (rd_data0)
  );

  assign core_data = rd_data0;
`endif

  // --------------------------------------------------------------------------
  // Run FSM. Outputs are registered alongside the state so that each output
  // describes the state being entered.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          core_en_q <= 1'b0;
          count_q   <= '0;
          done_q    <= 1'b0;
          if (run_full) begin
            state_q    <= START;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        START: begin
          state_q    <= RUN;
          core_rst_q <= 1'b0;
          core_en_q  <= 1'b1;
          count_q    <= '0;
          busy_q     <= 1'b1;
          done_q     <= 1'b0;
        end
        RUN: begin
          core_rst_q <= 1'b0;
          if (count_q == C_LAST) begin
            state_q   <= IDLE;
            core_en_q <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
          end else begin
            core_en_q <= 1'b1;
            count_q   <= count_inc;
            busy_q    <= 1'b1;
            // done is registered, so raise it on entry to the final count.
            done_q    <= (count_inc == C_LAST);
          end
        end
        default: begin
          state_q    <= IDLE;
          core_rst_q <= 1'b0;
          core_en_q  <= 1'b0;
          count_q    <= '0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst   = core_rst_q;
  assign core_en    = core_en_q;
  assign core_count = count_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : inverse_feeder
`default_nettype wire
